// File: rtl/rbs40_seq.sv
// ---------------------------------------------------------------------------
// rbs40_seq -- multi-cycle ripple-borrow subtractor
//
// Computes D = A - B - Bin (mod 2^WIDTH). Each cycle handles one CHUNK-bit
// slice, and a borrow register carries the borrow from one slice to the next.
// It is the subtracting companion of the ripple-carry adder and follows the
// same operand width and the same borrow-in / borrow-out convention.
//
// Ports
//   clk        in   1      clock; all state updates on the rising edge
//   reset      in   1      synchronous, active-high reset
//   A          in   WIDTH  minuend, sampled on accept
//   B          in   WIDTH  subtrahend, sampled on accept
//   Bin        in   1      borrow-in, sampled on accept
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   D          out  WIDTH  difference A - B - Bin mod 2^WIDTH
//   Bout       out  1      borrow-out: unsigned A < B + Bin
//   V          out  1      signed overflow
//   out_valid  out  1      D / Bout / V valid
//   out_ready  in   1      consumer takes the result
// ---------------------------------------------------------------------------
module rbs40_seq #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_v;
  logic             r_out_valid;

  logic [IW-1:0]    w_lo;
  logic [CHUNK-1:0] w_a_k;
  logic [CHUNK-1:0] w_b_k;
  logic [CHUNK:0]   w_sub;

  // Low bit index of the slice handled this cycle.
  assign w_lo  = IW'(r_cnt) * IW'(CHUNK);
  assign w_a_k = r_a[w_lo +: CHUNK];
  assign w_b_k = r_b[w_lo +: CHUNK];

  // CHUNK+1 bit subtract: the top bit is set exactly when the slice
  // underflows, which makes it the borrow into the next slice.
  assign w_sub = {1'b0, w_a_k} - {1'b0, w_b_k} - {{CHUNK{1'b0}}, r_borrow};

  assign in_ready  = (r_state == S_IDLE);
  assign D         = r_d;
  assign Bout      = r_bout;
  assign V         = r_v;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
            r_d      <= '0;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_d[w_lo +: CHUNK] <= w_sub[CHUNK-1:0];
          r_borrow           <= w_sub[CHUNK];
          if (r_cnt == LAST) begin
            // Last slice: its diff MSB is the final D MSB.
            r_bout      <= w_sub[CHUNK];
            r_v         <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                           (r_a[WIDTH-1] ^ w_sub[CHUNK-1]);
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbs40_seq.sv
// ---------------------------------------------------------------------------
// tb_rbs40_seq -- self-checking bench for rbs40_seq.
// Expected results come from whole-word 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_rbs40_seq;

  localparam int W = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         out_valid;
  logic         out_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rbs40_seq #(.WIDTH(40), .CHUNK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int hold);
    logic [63:0]  ea, eb, full;
    logic [W-1:0] ed;
    logic         ebout, ev;
    logic [W-1:0] hd;
    logic         hb, hv;
    int           lat;
    ea    = 64'(a);
    eb    = 64'(b);
    full  = ea - eb - 64'(bin);
    ed    = full[W-1:0];
    ebout = (ea < eb + 64'(bin));
    ev    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ ed[W-1]);

    check("in_ready_idle", 64'(in_ready), 64'(1));
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
    step();
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_run", 64'(in_ready), 64'(0));
      in_valid = 1'($urandom_range(0, 1));
      A = rnd40(); B = rnd40(); Bin = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(5));
    check("D", 64'(D), 64'(ed));
    check("Bout", 64'(Bout), 64'(ebout));
    check("V", 64'(V), 64'(ev));

    hd = D; hb = Bout; hv = V;
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      A = rnd40(); B = rnd40(); Bin = 1'($urandom_range(0, 1));
      step();
      check("hold_D", 64'(D), 64'(hd));
      check("hold_Bout", 64'(Bout), 64'(hb));
      check("hold_V", 64'(V), 64'(hv));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_out_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'(0));
    check("drain_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    step();
    step();
    check("rst_D", 64'(D), 64'(0));
    check("rst_Bout", 64'(Bout), 64'(0));
    check("rst_V", 64'(V), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;
    step();

    // Directed vectors
    run_op(40'h0000000010, 40'h0000000003, 1'b0, 0);
    run_op(40'h0100000000, 40'h0000000001, 1'b0, 0);
    run_op(40'h0000000000, 40'h0000000001, 1'b0, 0);
    run_op(40'h0000012345, 40'h0000012345, 1'b1, 0);
    run_op(40'h7FFFFFFFFF, 40'hFFFFFFFFFF, 1'b0, 0);
    run_op(40'h8000000000, 40'h0000000001, 1'b0, 0);
    run_op(40'hFFFFFFFFFF, 40'h0000000000, 1'b1, 10);

    // Reset in RUN after two slices (cnt == 2)
    A = 40'hABCDEF0123; B = 40'h0123456789; Bin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_D", 64'(D), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 8; i++) begin
      step();
      check("midrst_no_result", 64'(out_valid), 64'(0));
    end
    run_op(40'h0000000005, 40'h0000000007, 1'b0, 0);

    // Reset together with in_valid: no accept
    A = 40'h1111111111; B = 40'h0000000001; Bin = 1'b0;
    reset = 1'b1; in_valid = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("rstacc_in_ready", 64'(in_ready), 64'(1));
      check("rstacc_out_valid", 64'(out_valid), 64'(0));
      step();
    end

    // Randomized operations, biased toward edge operands
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      ra = rnd40();
      rb = rnd40();
      case (sel)
        1: rb = ra;
        2: ra = ($urandom_range(0, 1) != 0) ? '0 : '1;
        3: begin ra[W-1] = ~rb[W-1]; end
        4: rb = '1;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
